dac_sample_writer: RTL

//  Consumer end of the Oscillator sample stream. Accepts signed Q2.30 samples (out_1) over a

---
 rtl/dds_pkg.sv | 9 +
 rtl/dac_sample_fifo.sv | 39 +++
 rtl/dac_sample_writer.sv | 83 ++++++++
 3 files changed

// File: rtl/dds_pkg.sv
// dds_pkg: shared Q-format constants, sample-writer FSM states and DAC midscale helper.
package dds_pkg;
  localparam int Q_FRAC = 30;
  localparam int SAMPLE_W = 32;
  typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;
  function automatic logic [15:0] midscale(input int w);
    return 16'(1) << (w - 1);
  endfunction
endpackage

// File: rtl/dac_sample_fifo.sv
// dac_sample_fifo: synchronous show-ahead FIFO with occupancy level and flush.
module dac_sample_fifo #(
  parameter int W = 14,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign full = level == LW'(DEPTH);
  assign empty = level == '0;
  assign dout = mem[rp];
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
  always_ff @(posedge clk)
    if (rst || clr) begin
      wp <= '0;
      rp <= '0;
      level <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
      level <= level + LW'(do_push) - LW'(do_pop);
    end
endmodule

// File: rtl/dac_sample_writer.sv
// dac_sample_writer: converts Q2.30 samples to offset-binary DAC codes and paces them out every DIV_N cycles.
module dac_sample_writer
  import dds_pkg::*;
#(
  parameter int DAC_W = 14,
  parameter int DIV_N = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int PRIME_LVL = 2
) (
  input  logic                Fg_CLK,
  input  logic                Fg_RESET,
  input  logic                iEnable,
  input  logic [SAMPLE_W-1:0] iSample,
  input  logic                iSampleValid,
  output logic                oSampleReady,
  output logic [DAC_W-1:0]    oDacData,
  output logic                oDacWr,
  output logic                oUnderflow,
  output logic                oRunning
);
  localparam int CW = $clog2(DIV_N);
  localparam int OW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [DAC_W-1:0] MID = DAC_W'(midscale(DAC_W));
  localparam logic signed [32:0] Q_MAX = (33'sd1 <<< Q_FRAC) - 33'sd1;
  localparam logic signed [32:0] Q_MIN = -(33'sd1 <<< Q_FRAC);
  localparam logic signed [32:0] RND = 33'sd1 <<< (Q_FRAC - DAC_W);
  state_t state;
  logic [CW-1:0] cnt;
  logic signed [32:0] s_ext, s_clip, r, r_sat;
  logic [DAC_W-1:0] code, head;
  logic full, empty, tick, push, pop;
  logic [OW-1:0] level;
  // Clip to [-1, 1), round half-up by adding half an LSB, then flip the sign bit for offset binary.
  always_comb begin
    s_ext = {iSample[SAMPLE_W-1], iSample};
    s_clip = s_ext > Q_MAX ? Q_MAX : (s_ext < Q_MIN ? Q_MIN : s_ext);
    r = s_clip + RND;
    r_sat = r > Q_MAX ? Q_MAX : r;
    code = DAC_W'(r_sat >>> (Q_FRAC + 1 - DAC_W)) ^ MID;
  end
  assign oSampleReady = state != IDLE && !full;
  assign push = iSampleValid && oSampleReady;
  assign tick = state != IDLE && cnt == CW'(DIV_N - 1);
  assign pop = iEnable && tick && !empty && (state == RUN || level >= OW'(PRIME_LVL));
  assign oRunning = state == RUN;
  dac_sample_fifo #(.W(DAC_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(Fg_CLK),
    .rst(Fg_RESET),
    .clr(!iEnable),
    .push(push),
    .pop(pop),
    .din(code),
    .dout(head),
    .full(full),
    .empty(empty),
    .level(level)
  );
  always_ff @(posedge Fg_CLK)
    if (Fg_RESET) begin
      state <= IDLE;
      cnt <= '0;
      oDacData <= MID;
      oDacWr <= 1'b0;
      oUnderflow <= 1'b0;
    end else begin
      oDacWr <= pop || (!iEnable && state != IDLE);
      if (!iEnable) begin
        state <= IDLE;
        cnt <= '0;
        oUnderflow <= 1'b0;
        oDacData <= MID;
      end else if (state == IDLE) begin
        state <= PRIME;
        cnt <= '0;
      end else begin
        cnt <= tick ? '0 : cnt + 1'b1;
        if (pop) begin
          state <= RUN;
          oDacData <= head;
        end else if (tick && state == RUN) oUnderflow <= 1'b1;
      end
    end
endmodule
